pipeline_hazard_controller: RTL and testbench

- Hazard and sequencing controller for the 5-stage pipeline (F/D/E/M/W registers, branch resolved in M).
- Generates stall and flush enables for each pipeline register, plus ForwardA/B selects for the E-stage ALU operand muxes.
- Sequences multi-cycle data-memory accesses through a wait FSM with a timeout.
- Keeps saturating performance counters for stall cycles and branch flushes.

---
 rtl/pipeline_hazard_controller.sv | 177 +++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard, forwarding and memory-wait sequencing for the 5-stage pipeline.
// Also keeps saturating stall-cycle and branch-flush counters.
module pipeline_hazard_controller #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             PCSrcM,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam logic RUN      = 1'b0;
   localparam logic MEM_WAIT = 1'b1;

   localparam logic [7:0]       TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_fault_q, mem_fault_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic lwstall;
   logic membusy;
   logic hold;
   logic br_flush;

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       wr_m,
      input logic [4:0] dst_m,
      input logic       wr_w,
      input logic [4:0] dst_w
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_m && dst_m != 5'd0 && dst_m == src) begin
         sel = 2'b10;
      end else if (wr_w && dst_w != 5'd0 && dst_w == src) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   assign lwstall = MemtoRegE && RtE != 5'd0 && (RtE == RsD || RtE == RtD);
   assign membusy = dmem_req && !dmem_ready;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_fault_d = mem_fault_q;
      hold        = 1'b0;
      unique case (state_q)
         RUN: begin
            if (membusy) begin
               hold       = 1'b1;
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (!membusy) begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q >= TO_LAST) begin
               // Give up on the access; read data is garbage from here.
               mem_fault_d = 1'b1;
               state_d     = RUN;
               wait_cnt_d  = 8'd0;
            end else begin
               hold       = 1'b1;
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   always_comb begin
      StallF   = 1'b0;
      StallD   = 1'b0;
      StallE   = 1'b0;
      StallM   = 1'b0;
      FlushD   = 1'b0;
      FlushE   = 1'b0;
      FlushM   = 1'b0;
      FlushW   = 1'b0;
      br_flush = 1'b0;
      if (reset) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushM = 1'b1;
         FlushW = 1'b1;
      end else if (hold) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcM) begin
         // Branch wins over load-use: the dependent op is squashed anyway.
         FlushD   = 1'b1;
         FlushE   = 1'b1;
         FlushM   = 1'b1;
         br_flush = 1'b1;
      end else if (lwstall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallF && stall_cnt_q != CNT_MAX) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (br_flush && flush_cnt_q != CNT_MAX) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         wait_cnt_q  <= 8'd0;
         mem_fault_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_fault_q <= mem_fault_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ForwardAE = reset ? 2'b00 :
      fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
   assign ForwardBE = reset ? 2'b00 :
      fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);

   assign mem_fault    = mem_fault_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with a cycle-level
// reference model checked on every falling edge.
module tb_pipeline_hazard_controller;

   localparam int CNT_W = 4;
   localparam int TO    = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic [4:0]       RsD, RtD, RsE, RtE, WriteRegM, WriteRegW;
   logic             RegWriteM, RegWriteW, MemtoRegE, PCSrcM;
   logic             dmem_req, dmem_ready;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushM, FlushW;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             mem_fault;
   logic [CNT_W-1:0] stall_cycles, flush_events;

   int vectors     = 0;
   int miscompares = 0;

   pipeline_hazard_controller #(
      .CNT_W(CNT_W),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .PCSrcM(PCSrcM),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mem_fault(mem_fault),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state: stalled cycles spent on the current access, fault, counters
   int m_waited = 0, n_waited = 0;
   int m_fault  = 0, n_fault  = 0;
   int m_scnt   = 0, n_scnt   = 0;
   int m_fcnt   = 0, n_fcnt   = 0;

   function automatic int fwd(input logic [4:0] src);
      if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2;
      if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 1;
      return 0;
   endfunction

   always @(negedge clk) begin
      int sf, sd, se, sm, fd, fe, fm, fw, fa, fb;
      int busy, hold, lw;
      sf = 0; sd = 0; se = 0; sm = 0;
      fd = 0; fe = 0; fm = 0; fw = 0;
      fa = 0; fb = 0;
      if (reset) begin
         fd = 1; fe = 1; fm = 1; fw = 1;
         n_waited = 0; n_fault = 0; n_scnt = 0; n_fcnt = 0;
      end else begin
         busy = int'(dmem_req && !dmem_ready);
         hold = int'(busy != 0 && (m_waited == 0 || m_waited < TO - 1));
         lw = int'(MemtoRegE && RtE != 0 && (RtE == RsD || RtE == RtD));
         fa = fwd(RsE);
         fb = fwd(RtE);
         n_fault  = m_fault;
         n_fcnt   = m_fcnt;
         n_waited = 0;
         if (hold != 0) begin
            sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
            n_waited = m_waited + 1;
         end else begin
            if (busy != 0 && m_waited != 0) n_fault = 1;
            if (PCSrcM) begin
               fd = 1; fe = 1; fm = 1;
               n_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
            end else if (lw != 0) begin
               sf = 1; sd = 1; fe = 1;
            end
         end
         n_scnt = (sf != 0 && m_scnt < CMAX) ? m_scnt + 1 : m_scnt;
      end
      chk("StallF", int'(StallF), sf);
      chk("StallD", int'(StallD), sd);
      chk("StallE", int'(StallE), se);
      chk("StallM", int'(StallM), sm);
      chk("FlushD", int'(FlushD), fd);
      chk("FlushE", int'(FlushE), fe);
      chk("FlushM", int'(FlushM), fm);
      chk("FlushW", int'(FlushW), fw);
      chk("ForwardAE", int'(ForwardAE), fa);
      chk("ForwardBE", int'(ForwardBE), fb);
      chk("mem_fault", int'(mem_fault), m_fault);
      chk("stall_cycles", int'(stall_cycles), m_scnt);
      chk("flush_events", int'(flush_events), m_fcnt);
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_waited <= 0; m_fault <= 0; m_scnt <= 0; m_fcnt <= 0;
      end else begin
         m_waited <= n_waited; m_fault <= n_fault;
         m_scnt <= n_scnt; m_fcnt <= n_fcnt;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      RsD = 5'd1; RtD = 5'd2; RsE = 5'd8; RtE = 5'd9;
      WriteRegM = 5'd0; WriteRegW = 5'd0;
      RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemtoRegE = 1'b0; PCSrcM = 1'b0;
      dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      RegWriteM = 1'b1; WriteRegM = 5'd8;
      step(); #1;
      chk("rst_FlushD", int'(FlushD), 1);
      chk("rst_FlushW", int'(FlushW), 1);
      chk("rst_StallF", int'(StallF), 0);
      chk("rst_ForwardAE", int'(ForwardAE), 0);
      chk("rst_stall_cycles", int'(stall_cycles), 0);
      step();
      reset = 1'b0;
      idle();

      // Forwarding: M beats W, r0 never forwards, W-only match
      step();
      RegWriteM = 1'b1; WriteRegM = 5'd3;
      RegWriteW = 1'b1; WriteRegW = 5'd3; RsE = 5'd3;
      #1 chk("fwd_m_prio", int'(ForwardAE), 2);
      step();
      WriteRegM = 5'd0; WriteRegW = 5'd0; RsE = 5'd0;
      #1 chk("fwd_r0", int'(ForwardAE), 0);
      step();
      WriteRegM = 5'd4; WriteRegW = 5'd7; RtE = 5'd7;
      #1 chk("fwd_w_only", int'(ForwardBE), 1);

      // Load-use bubble
      step();
      idle(); MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
      #1 chk("lw_StallF", int'(StallF), 1);
      chk("lw_FlushE", int'(FlushE), 1);
      step();
      idle();
      #1 chk("lw_after_StallF", int'(StallF), 0);
      chk("lw_stall_cycles", int'(stall_cycles), 1);

      // Branch overrides load-use
      step();
      MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; PCSrcM = 1'b1;
      #1 chk("br_FlushM", int'(FlushM), 1);
      chk("br_StallF", int'(StallF), 0);
      step();
      idle();
      #1 chk("br_flush_events", int'(flush_events), 1);

      // Memory wait with a pending branch, then back-to-back access
      for (int i = 0; i < 3; i++) begin
         step();
         dmem_req = 1'b1; dmem_ready = 1'b0; PCSrcM = 1'b1;
         #1 chk("mw_StallM", int'(StallM), 1);
         chk("mw_FlushM", int'(FlushM), 0);
      end
      step();
      dmem_ready = 1'b1;
      #1 chk("mw_rel_FlushD", int'(FlushD), 1);
      chk("mw_rel_StallF", int'(StallF), 0);
      chk("mw_stall_cycles", int'(stall_cycles), 4);
      step();
      dmem_ready = 1'b0; PCSrcM = 1'b0;
      #1 chk("b2b_StallF", int'(StallF), 1);
      chk("b2b_flush_events", int'(flush_events), 2);
      step();
      dmem_ready = 1'b1;
      step();
      idle();
      #1 chk("b2b_stall_cycles", int'(stall_cycles), 5);

      // Request dropped mid-wait counts as completion
      step();
      dmem_req = 1'b1;
      step();
      dmem_req = 1'b0;
      #1 chk("drop_StallF", int'(StallF), 0);

      // Timeout
      for (int i = 0; i < 3; i++) begin
         step();
         dmem_req = 1'b1; dmem_ready = 1'b0;
         #1 chk("to_StallF", int'(StallF), 1);
      end
      step();
      #1 chk("to_rel_StallF", int'(StallF), 0);
      chk("to_pre_fault", int'(mem_fault), 0);
      step();
      #1 chk("to_fault", int'(mem_fault), 1);
      chk("to_reenter", int'(StallF), 1);
      step();
      idle();
      step();
      #1 chk("to_sticky", int'(mem_fault), 1);

      // Saturation over 20 load-use stall cycles
      for (int i = 0; i < 20; i++) begin
         step();
         MemtoRegE = 1'b1; RtE = 5'd6; RtD = 5'd6;
      end
      step();
      idle();
      #1 chk("sat_stall_cycles", int'(stall_cycles), CMAX);

      // Reset in the middle of a wait
      step();
      dmem_req = 1'b1;
      step();
      #1 reset = 1'b1;
      #1 chk("rmid_FlushE", int'(FlushE), 1);
      chk("rmid_StallF", int'(StallF), 0);
      chk("rmid_stall_cycles", int'(stall_cycles), 0);
      chk("rmid_fault", int'(mem_fault), 0);
      step();
      reset = 1'b0;
      idle(); PCSrcM = 1'b1;
      #1 chk("rmid_run_FlushD", int'(FlushD), 1);
      chk("rmid_run_StallF", int'(StallF), 0);
      step();
      idle();
      #1 chk("rmid_flush_events", int'(flush_events), 1);
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
